freq_count_bcd: RTL

FREQ_COUNT_BCD -- requirements
Module: freq_count_bcd

---
 rtl/freq_pkg.sv | 17 +
 rtl/bcd_decade.sv | 30 +++
 rtl/freq_count_bcd.sv | 115 +++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared encodings and constants for the BCD frequency counter.
package freq_pkg;

  typedef enum logic [1:0] {
    GATE  = 2'd0,
    LATCH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         NDIG_DEFAULT = 4;

  function automatic logic is_bcd_max(input logic [3:0] d);
    return (d == BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One decimal digit of the running count; carry is combinational so a
// whole chain of 9s rolls over in a single cycle.
module bcd_decade
  import freq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !sat) begin
      r_q <= is_bcd_max(r_q) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = inc && is_bcd_max(r_q);

endmodule

// File: rtl/freq_count_bcd.sv
// Gated BCD frequency counter: counts sig_in rising edges over CLK_HZ cycles.
// Build option FREQ_OVF_SATURATE_EN: hold the count at all-9s after overflow.
module freq_count_bcd
  import freq_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int NDIG   = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  output logic [4*NDIG-1:0] bcd_out,
  output logic              valid,
  output logic              overflow
);

  localparam int            GW        = $clog2(CLK_HZ + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(CLK_HZ - 1);

  logic              r_sync1, r_sync2, r_sync3;
  logic              w_edge;
  state_t            r_state;
  logic [GW-1:0]     r_gcnt;
  logic              r_ovf;
  logic [4*NDIG-1:0] r_bcd_out;
  logic              r_valid;
  logic              r_overflow;

  logic [NDIG-1:0]   w_inc;
  logic [NDIG-1:0]   w_carry;
  logic [4*NDIG-1:0] w_count;
  logic              w_clr;
  logic              w_sat;
  logic              w_ovf_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;

  // Only GATE-cycle edges enter the chain; LATCH/CLEAR edges are dropped.
  assign w_inc[0]  = (r_state == GATE) && w_edge;
  assign w_clr     = (r_state == CLEAR);
  assign w_ovf_evt = w_carry[NDIG-1];

`ifdef FREQ_OVF_SATURATE_EN
  assign w_sat = w_carry[NDIG-1];
`else
  assign w_sat = 1'b0;
`endif

  genvar k;
  generate
    for (k = 0; k < NDIG; k++) begin : g_dec
      if (k > 0) begin : g_link
        assign w_inc[k] = w_carry[k-1];
      end
      bcd_decade u_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_inc[k]),
        .sat   (w_sat),
        .q     (w_count[4*k +: 4]),
        .carry (w_carry[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_gcnt     <= '0;
      r_ovf      <= 1'b0;
      r_bcd_out  <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        GATE: begin
          if (w_ovf_evt) r_ovf <= 1'b1;
          if (r_gcnt == GATE_LAST) r_state <= LATCH;
          else                     r_gcnt  <= r_gcnt + 1'b1;
        end
        LATCH: begin
          r_bcd_out  <= w_count;
          r_overflow <= r_ovf;
          r_valid    <= 1'b1;
          r_state    <= CLEAR;
        end
        CLEAR: begin
          r_gcnt  <= '0;
          r_ovf   <= 1'b0;
          r_state <= GATE;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign bcd_out  = r_bcd_out;
  assign valid    = r_valid;
  assign overflow = r_overflow;

endmodule
